// File: rtl/multi_port_ram.sv
// multi_port_ram: single-write, NUM_READ-read synchronous RAM with registered
// reads, per-port valid, and a hardware clear engine that zeroes the array
// one word per cycle after reset or on a clear request.
// Build option: define MPRAM_BYPASS_EN for write-first read/write collisions;
// leave it undefined for read-first collisions.
module multi_port_ram #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_READ   = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           we,
    input  logic [ADDR_WIDTH-1:0]          write_addr,
    input  logic [DATA_WIDTH-1:0]          write_data,
    input  logic                           clear,
    input  logic [NUM_READ-1:0]            read_en,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] read_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0] read_data,
    output logic [NUM_READ-1:0]            read_valid,
    output logic                           ready
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

`ifdef MPRAM_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // State register; reset always restarts a clear pass.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_next;
        end
    end

    // Next state: leave CLEAR after the last word, enter it on a clear request.
    always_comb begin
        state_next = state;
        case (state)
            ST_CLEAR: if (clr_cnt == LAST_ADDR) state_next = ST_READY;
            ST_READY: if (clear)                state_next = ST_CLEAR;
            default:                            state_next = ST_CLEAR;
        endcase
    end

    // Outputs decoded from state: the array is usable only in READY.
    always_comb begin
        ready = 1'b0;
        if (state == ST_READY) ready = 1'b1;
    end

    // Clear address counter; parks on the last address rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            if (clr_cnt != LAST_ADDR) clr_cnt <= clr_cnt + 1'b1;
        end else if (clear) begin
            clr_cnt <= '0;
        end
    end

    // Array write port: clear engine owns it during CLEAR, user write otherwise.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == ST_CLEAR) begin
                mem[clr_cnt] <= '0;
            end else if (we) begin
                mem[write_addr] <= write_data;
            end
        end
    end

    for (genvar g = 0; g < NUM_READ; g++) begin : g_read
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data_q;
        logic                  valid_q;

        assign addr = read_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign read_data[g*DATA_WIDTH +: DATA_WIDTH] = data_q;
        assign read_valid[g] = valid_q;

        // Registered read; data holds whenever no read is accepted.
        always_ff @(posedge clk) begin
            if (reset) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= 1'b0;
                if (state == ST_READY && read_en[g]) begin
                    valid_q <= 1'b1;
                    if (BYPASS && we && (write_addr == addr)) begin
                        data_q <= write_data;
                    end else begin
                        data_q <= mem[addr];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_port_ram.sv
// Testbench for multi_port_ram (ADDR_WIDTH=4, DATA_WIDTH=8, NUM_READ=2).
// Reads push expected words into per-port queues; a negedge monitor pops and
// compares whenever read_valid is presented. Expected collision data follows
// the MPRAM_BYPASS_EN define.
module tb_multi_port_ram;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned NR = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          we;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] write_data;
    logic          clear;
    logic [NR-1:0] read_en;
    logic [NR*AW-1:0] read_addr;
    logic [NR*DW-1:0] read_data;
    logic [NR-1:0] read_valid;
    logic          ready;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] exp_q0[$];
    logic [DW-1:0] exp_q1[$];

`ifdef MPRAM_BYPASS_EN
    localparam logic [DW-1:0] COLL_EXP = 8'h5A;
`else
    localparam logic [DW-1:0] COLL_EXP = 8'hA5;
`endif

    multi_port_ram #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .NUM_READ  (NR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .write_addr(write_addr),
        .write_data(write_data),
        .clear     (clear),
        .read_en   (read_en),
        .read_addr (read_addr),
        .read_data (read_data),
        .read_valid(read_valid),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we      = 1'b0;
        clear   = 1'b0;
        read_en = '0;
    endtask

    // Issue a read on both ports and record what each must return.
    task automatic issue_read(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                              input logic [DW-1:0] e0, input logic [DW-1:0] e1);
        read_en   = 2'b11;
        read_addr = {a1, a0};
        exp_q0.push_back(e0);
        exp_q1.push_back(e1);
    endtask

    // Monitor: compare every presented read against the scoreboard.
    always @(negedge clk) begin
        if (read_valid[0] === 1'b1) begin
            if (exp_q0.size() == 0) begin
                check("p0_unexpected_valid", 32'd1, 32'd0);
            end else begin
                check("p0_data", {24'd0, read_data[7:0]}, {24'd0, exp_q0.pop_front()});
            end
        end
        if (read_valid[1] === 1'b1) begin
            if (exp_q1.size() == 0) begin
                check("p1_unexpected_valid", 32'd1, 32'd0);
            end else begin
                check("p1_data", {24'd0, read_data[15:8]}, {24'd0, exp_q1.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; idle();
        write_addr = '0; write_data = '0; read_addr = '0;

        // Reset held for two edges.
        step(); step();
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_valid", {30'd0, read_valid}, 32'd0);
        check("rst_data", {16'd0, read_data}, 32'd0);

        // Clear after reset: ready rises exactly at the 16th edge.
        reset = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            step();
            check($sformatf("clr_ready_e%0d", n), {31'd0, ready}, (n == 16) ? 32'd1 : 32'd0);
            check($sformatf("clr_valid_e%0d", n), {30'd0, read_valid}, 32'd0);
        end

        // Whole array reads zero on both ports.
        for (int a = 0; a < 16; a++) begin
            issue_read(AW'(a), AW'(15 - a), 8'h00, 8'h00);
            step();
        end
        idle();
        step();

        // Write then read, then hold with read_en low.
        we = 1'b1; write_addr = 4'd3; write_data = 8'hA5;
        step();
        we = 1'b0;
        issue_read(4'd3, 4'd4, 8'hA5, 8'h00);
        step();
        check("wr_rd_valid", {30'd0, read_valid}, 32'd3);
        idle();
        step();
        check("hold_valid", {30'd0, read_valid}, 32'd0);
        check("hold_data", {16'd0, read_data}, 32'h00A5);

        // Collision on addr 3 from both ports.
        we = 1'b1; write_addr = 4'd3; write_data = 8'h5A;
        issue_read(4'd3, 4'd3, COLL_EXP, COLL_EXP);
        step();
        we = 1'b0;
        issue_read(4'd3, 4'd3, 8'h5A, 8'h5A);
        step();
        idle();
        step();

        // Clear request with a same-cycle write and read.
        clear = 1'b1; we = 1'b1; write_addr = 4'd5; write_data = 8'h77;
        issue_read(4'd3, 4'd3, 8'h5A, 8'h5A);
        step();
        check("creq_ready_e0", {31'd0, ready}, 32'd0);
        clear = 1'b0;
        we = 1'b1; write_addr = 4'd9; write_data = 8'h11;
        read_en = 2'b11; read_addr = {4'd9, 4'd5};
        for (int n = 1; n <= 16; n++) begin
            step();
            we = 1'b0;
            check($sformatf("creq_ready_e%0d", n), {31'd0, ready}, (n == 16) ? 32'd1 : 32'd0);
            check($sformatf("creq_valid_e%0d", n), {30'd0, read_valid}, 32'd0);
            check($sformatf("creq_hold_e%0d", n), {16'd0, read_data}, 32'h5A5A);
        end
        idle();
        issue_read(4'd3, 4'd5, 8'h00, 8'h00);
        step();
        issue_read(4'd9, 4'd5, 8'h00, 8'h00);
        step();

        // Boundary addresses after the clear.
        idle();
        we = 1'b1; write_addr = 4'd15; write_data = 8'hC3;
        step();
        we = 1'b1; write_addr = 4'd0; write_data = 8'h3C;
        step();
        we = 1'b0;
        issue_read(4'd15, 4'd0, 8'hC3, 8'h3C);
        step();
        idle();
        step();

        // Reset mid-clear at clr_cnt=7 restarts the full pass.
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int k = 1; k <= 7; k++) step();
        check("mid_ready_pre", {31'd0, ready}, 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_data", {16'd0, read_data}, 32'd0);
        for (int n = 1; n <= 16; n++) begin
            step();
            check($sformatf("mid_ready_e%0d", n), {31'd0, ready}, (n == 16) ? 32'd1 : 32'd0);
        end
        issue_read(4'd15, 4'd0, 8'h00, 8'h00);
        step();
        idle();
        step(); step();

        check("q0_drain", exp_q0.size(), 32'd0);
        check("q1_drain", exp_q1.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
